uart_rx: RTL and testbench

UART receive front end for the command path. Samples the asynchronous serial line, recovers 8N1 bytes, and presents each good byte with a one-cycle strobe. The strobe drives the frame parser's byte-enable input directly, and the byte bus drives its data input. Bad stop bits are flagged and the byte is dropped, so the parser only ever sees well-framed bytes.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and the
// majority vote used for mid-bit sampling. The TX side imports this too.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200

   typedef logic [1:0] uart_state_t;
   localparam uart_state_t IDLE  = 2'd0;
   localparam uart_state_t START = 2'd1;
   localparam uart_state_t DATA  = 2'd2;
   localparam uart_state_t STOP  = 2'd3;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, one-cycle strobe per
// good byte, framing errors flagged and the byte dropped.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_V0   = CW'(HALF - 1);
   localparam logic [CW-1:0] C_V1   = CW'(HALF);
   localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

   if (CLKS_PER_BIT < 8) begin : g_bad_cfg
      $error("uart_rx: CLKS_PER_BIT must be >= 8");
   end

   logic          rx_s;
   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          v0, v1;
   logic          armed;
   logic [1:0]    primed;
   logic          vote, wrap, dec;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   assign vote = maj3(v0, v1, rx_s);
   assign wrap = (cnt == C_LAST);
   assign dec  = (cnt == C_DEC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         v0        <= 1'b1;
         v1        <= 1'b1;
         armed     <= 1'b0;
         primed    <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         // The sync flops leave reset at 1; that value must not arm us, only a real line high may.
         primed    <= {primed[0], 1'b1};
         if (cnt == C_V0) v0 <= rx_s;
         if (cnt == C_V1) v1 <= rx_s;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (rx_s && primed[1]) armed <= 1'b1;
               // The detect cycle is cnt 0 of the start bit, so the counter resumes at 1.
               if (armed && !rx_s) begin
                  cnt     <= CW'(1);
                  state   <= START;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               cnt <= wrap ? '0 : cnt + 1'b1;
               if (dec && vote) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end else if (wrap) begin
                  state <= DATA;
                  idx   <= '0;
               end
            end
            DATA: begin
               cnt <= wrap ? '0 : cnt + 1'b1;
               if (dec) shreg[idx] <= vote;
               if (wrap) begin
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               cnt <= wrap ? '0 : cnt + 1'b1;
               // Finish at mid-stop so a start edge half a bit later is still seen.
               if (dec) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
                  cnt     <= '0;
                  if (vote) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     armed     <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected strobes and
// busy lengths; independent negedge monitors pop and compare.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int BUSY = 9 * CPB + HALF + 1;  // 153
   localparam int GLITCH_BUSY = HALF + 1;     // 9

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, rx_busy;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   busy_q[$];
   int   checks = 0;
   int   failures = 0;
   int   blen = 0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   // Drive one 8N1 frame; optionally invert rx for slen cycles starting at
   // cycle s0 of data bit sbit.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int sbit, input int s0, input int slen);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < CPB; c++) begin
            rx = f[k] ^ ((k == sbit + 1) && (c >= s0) && (c < s0 + slen));
            tick();
         end
      end
   endtask

   task automatic expect_good(input logic [7:0] b);
      sb_q.push_back('{err: 1'b0, data: b});
      busy_q.push_back(BUSY);
   endtask

   // Strobe monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (rx_valid || frame_err)) begin
         chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
         if (sb_q.size() == 0) begin
            chk("unexpected_strobe", {22'd0, rx_valid, frame_err, rx_data}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
         end
      end
   end

   // Busy-window monitor
   always @(negedge clk) begin
      if (!rst_n) blen = 0;
      else if (rx_busy) blen++;
      else if (blen != 0) begin
         if (busy_q.size() == 0) chk("unexpected_busy", blen, 0);
         else chk("busy_len", blen, busy_q.pop_front());
         blen = 0;
      end
   end

   logic [7:0] stream [13];

   initial begin
      stream = '{8'h52, 8'h0D, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'hA1, 8'h9A};

      // Reset state
      repeat (3) tick();
      chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
      chk("reset_rx_valid", {31'd0, rx_valid}, 0);
      chk("reset_frame_err", {31'd0, frame_err}, 0);
      chk("reset_rx_busy", {31'd0, rx_busy}, 0);
      rst_n = 1'b1;
      idle(10);

      // 1: single byte
      expect_good(8'h52);
      send_frame(8'h52, 1'b1, -1, 0, 0);
      idle(20);

      // 2: 4-cycle low glitch, then a real byte
      busy_q.push_back(GLITCH_BUSY);
      rx = 1'b0;
      repeat (4) tick();
      idle(40);
      expect_good(8'hA5);
      send_frame(8'hA5, 1'b1, -1, 0, 0);
      idle(20);

      // 3: bad stop bit, line stuck low, then recovery
      sb_q.push_back('{err: 1'b1, data: 8'hA5});
      busy_q.push_back(BUSY);
      send_frame(8'h3C, 1'b0, -1, 0, 0);
      rx = 1'b0;
      repeat (64) tick();
      chk("stuck_low_busy", {31'd0, rx_busy}, 0);
      chk("hold_after_ferr", {24'd0, rx_data}, 32'hA5);
      idle(20);
      expect_good(8'h0D);
      send_frame(8'h0D, 1'b1, -1, 0, 0);
      idle(20);

      // 4: back-to-back stream, sum 0xFF
      foreach (stream[i]) expect_good(stream[i]);
      foreach (stream[i]) send_frame(stream[i], 1'b1, -1, 0, 0);
      idle(20);

      // 5: spikes on data bit 3
      expect_good(8'h00);
      send_frame(8'h00, 1'b1, 3, HALF, 1);
      idle(20);
      expect_good(8'h08);
      send_frame(8'h00, 1'b1, 3, HALF - 1, 3);
      idle(20);

      // 6: reset mid bit 4 of 0x9A, released with rx low
      rx = 1'b0;
      repeat (CPB) tick();
      for (int k = 0; k < 4; k++) begin
         rx = k[0];  // bits 0..3 of 0x9A = 0,1,0,1
         repeat (CPB) tick();
      end
      rx = 1'b1;
      repeat (HALF) tick();
      chk("busy_before_reset", {31'd0, rx_busy}, 1);
      rx = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("async_rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("async_rst_rx_busy", {31'd0, rx_busy}, 0);
      chk("async_rst_rx_valid", {31'd0, rx_valid}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (12 * CPB) tick();
      chk("post_rst_low_busy", {31'd0, rx_busy}, 0);
      chk("post_rst_low_data", {24'd0, rx_data}, 32'h00);
      idle(20);
      expect_good(8'h9A);
      send_frame(8'h9A, 1'b1, -1, 0, 0);
      idle(50);

      chk("sb_drained", sb_q.size(), 0);
      chk("busy_q_drained", busy_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
